// File: rtl/axi_pkg.sv
// Shared AXI4 types and helpers for the memory-backed responder.
// Burst/response encodings plus the burst legality rule used by both address generators.
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  localparam int AXI_LEN_W  = 8;
  localparam int AXI_SIZE_W = 3;

  // Byte-offset bits within one data word.
  function automatic int axi_addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic logic axi_burst_legal(input logic [1:0] burst,
                                           input logic [AXI_LEN_W-1:0] len,
                                           input logic [AXI_SIZE_W-1:0] size,
                                           input int max_size);
    logic ok;
    ok = (int'(size) <= max_size) && (burst != 2'b11);
    if (burst == WRAP)
      ok = ok && ((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
    return ok;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Per-direction AXI burst address sequencer: loads the request, steps once per accepted beat.
// Illegal requests are flagged in err and sequenced as INCR.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_SIZE   = 2
) (
  input  logic                  clk,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [AXI_LEN_W-1:0]  len,
  input  logic [AXI_SIZE_W-1:0] size,
  input  logic [1:0]            burst,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  err
);

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [AXI_LEN_W-1:0]  len_q;
  logic [AXI_SIZE_W-1:0] size_q;
  axi_burst_e            burst_q;
  logic                  err_q;
  logic                  legal;

  assign legal     = axi_burst_legal(burst, len, size, MAX_SIZE);
  assign step      = ADDR_WIDTH'(1) << size_q;
  // Container is (len+1)*step bytes; mask selects the offset inside it.
  assign wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);

  always_comb begin
    next_addr = addr_q + step;
    case (burst_q)
      FIXED:   next_addr = addr_q;
      WRAP:    next_addr = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
      default: next_addr = addr_q + step;
    endcase
  end

  always_ff @(posedge clk) begin
    if (load) begin
      addr_q  <= base_addr;
      len_q   <= len;
      size_q  <= size;
      burst_q <= legal ? axi_burst_e'(burst) : INCR;
      err_q   <= !legal;
    end else if (advance) begin
      addr_q  <= next_addr;
    end
  end

  assign addr = addr_q;
  assign err  = err_q;

endmodule

// File: rtl/axi4_mem_slave.sv
// AXI4 responder backed by a word-addressed memory; independent single-outstanding read/write FSMs.
// Optional macro AXI_SLV_BACKPRESSURE_EN throttles readies and rvalid from a 16-bit LFSR.
module axi4_mem_slave
  import axi_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          ID_WIDTH   = 4,
  parameter int          MEM_DEPTH  = 1024,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int ADDR_LSB = axi_addr_lsb(DATA_WIDTH);
  localparam int IDX_W    = $clog2(MEM_DEPTH);
  localparam int STRB_W   = DATA_WIDTH / 8;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [1:0]            w_state;
  logic [7:0]            w_beat, w_len;
  logic [ID_WIDTH-1:0]   w_id;
  logic                  w_err, w_ag_err;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [IDX_W-1:0]      w_idx;

  logic [0:0]            r_state;
  logic [7:0]            r_beat, r_len;
  logic [ID_WIDTH-1:0]   r_id;
  logic                  r_ag_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [IDX_W-1:0]      r_idx;

  logic bp_aw, bp_w, bp_ar, bp_r;
  logic aw_hs, w_hs, ar_hs, r_hs;

`ifdef AXI_SLV_BACKPRESSURE_EN
  logic [15:0] lfsr;
  logic        r_held;

  // Taps 16,14,13,11; r_held keeps rvalid up once shown until the beat is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr   <= LFSR_SEED;
      r_held <= 1'b0;
    end else begin
      lfsr   <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      r_held <= rvalid && !rready;
    end
  end

  assign bp_aw = lfsr[0];
  assign bp_w  = lfsr[5];
  assign bp_ar = lfsr[10];
  assign bp_r  = lfsr[15] | r_held;
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
  assign bp_aw = 1'b1;
  assign bp_w  = 1'b1;
  assign bp_ar = 1'b1;
  assign bp_r  = 1'b1;
`endif

  assign awready = !rst && (w_state == W_IDLE) && bp_aw;
  assign wready  = !rst && (w_state == W_DATA) && bp_w;
  assign bvalid  = !rst && (w_state == W_RESP);
  assign bid     = bvalid ? w_id : '0;
  assign bresp   = (bvalid && (w_err || w_ag_err)) ? SLVERR : OKAY;

  assign arready = !rst && (r_state == R_IDLE) && bp_ar;
  assign rvalid  = !rst && (r_state == R_DATA) && bp_r;
  assign rid     = rvalid ? r_id : '0;
  assign rlast   = rvalid && (r_beat == r_len);
  assign rresp   = (rvalid && r_ag_err) ? SLVERR : OKAY;
  // Asynchronous read: a same-cycle write to this word lands only at the edge.
  assign rdata   = rvalid ? mem[r_idx] : '0;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;

  // Upper address bits alias; byte-offset bits are carried by strobes.
  assign w_idx = w_addr[ADDR_LSB +: IDX_W];
  assign r_idx = r_addr[ADDR_LSB +: IDX_W];

  logic unused_addr;
  assign unused_addr = ^{w_addr, r_addr};

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .MAX_SIZE(ADDR_LSB)) u_wr_addr (
    .clk(clk), .load(aw_hs), .base_addr(awaddr), .len(awlen), .size(awsize),
    .burst(awburst), .advance(w_hs), .addr(w_addr), .err(w_ag_err)
  );

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .MAX_SIZE(ADDR_LSB)) u_rd_addr (
    .clk(clk), .load(ar_hs), .base_addr(araddr), .len(arlen), .size(arsize),
    .burst(arburst), .advance(r_hs), .addr(r_addr), .err(r_ag_err)
  );

  always_ff @(posedge clk) begin
    if (aw_hs) begin
      w_id  <= awid;
      w_len <= awlen;
    end
    if (ar_hs) begin
      r_id  <= arid;
      r_len <= arlen;
    end
  end

  // Write FSM: beat count alone ends the burst; wlast only feeds the error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_beat  <= '0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (aw_hs) begin
          w_state <= W_DATA;
          w_beat  <= '0;
          w_err   <= 1'b0;
        end
        W_DATA: if (w_hs) begin
          if (wlast != (w_beat == w_len)) w_err <= 1'b1;
          if (w_beat == w_len) w_state <= W_RESP;
          else                 w_beat  <= w_beat + 8'd1;
        end
        W_RESP: if (bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_beat  <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (ar_hs) begin
          r_state <= R_DATA;
          r_beat  <= '0;
        end
        R_DATA: if (r_hs) begin
          if (rlast) r_state <= R_IDLE;
          else       r_beat  <= r_beat + 8'd1;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule
